// File: rtl/data_record_aligner_if.sv
// rtl/data_record_aligner_if.sv - Raw word input and aligned record output bundle for data_record_aligner
interface data_record_aligner_if;
    logic [39:0] rawWord;
    logic        resync;
    logic [39:0] dataRecord;
    logic        recordValid;
    logic        locked;
    logic [5:0]  bitOffset;
    logic [15:0] syncLossCount;
    logic [15:0] lockCount;

    // Deserializer / checker side: drives raw words, observes aligned records
    modport master (
        output rawWord,
        output resync,
        input  dataRecord,
        input  recordValid,
        input  locked,
        input  bitOffset,
        input  syncLossCount,
        input  lockCount
    );

    // Aligner side
    modport slave (
        input  rawWord,
        input  resync,
        output dataRecord,
        output recordValid,
        output locked,
        output bitOffset,
        output syncLossCount,
        output lockCount
    );
endinterface

// File: rtl/data_record_aligner.sv
// rtl/data_record_aligner.sv - Sync-pattern word aligner with idle substitution; ALIGNER_STATS_EN adds lock/loss counters
module data_record_aligner #(
    parameter int LOCK_COUNT = 8,
    parameter int MAX_GAP    = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    data_record_aligner_if.slave  bus
);
    localparam logic [39:0] IDLE_WORD = {16'h3C5C, 2'b10, 22'h2AAAAA};
    localparam logic [9:0]  MAX_GAP_V = 10'(MAX_GAP);
    localparam logic [7:0]  LOCK_V    = 8'(LOCK_COUNT);

    typedef enum logic [1:0] {
        SEARCH,
        VERIFY,
        LOCKED
    } state_t;

    state_t      state, state_nxt;
    logic [5:0]  offset, offset_nxt, offset_inc;
    logic [9:0]  gap_cnt, gap_cnt_nxt;
    logic [7:0]  hit_cnt, hit_cnt_nxt;
    logic [39:0] prev_word, cur_word;
    logic [79:0] window;
    logic [6:0]  shift_amt;
    logic [39:0] cand;
    logic        match;
    logic [39:0] data_record;

    // cand = window[79-offset -: 40], expressed as a right shift of the 80-bit window
    assign window     = {prev_word, cur_word};
    assign shift_amt  = 7'd40 - {1'b0, offset};
    assign cand       = 40'(window >> shift_amt);
    // Header (23:22=00) and idle (23:22=10) both carry the pattern with bit 22 clear
    assign match      = (cand[39:24] == 16'h3C5C) && !cand[22];
    assign offset_inc = (offset == 6'd39) ? 6'd0 : offset + 6'd1;

    // Two-word window of the raw deserializer stream
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_word <= '0;
            cur_word  <= '0;
        end else begin
            prev_word <= cur_word;
            cur_word  <= bus.rawWord;
        end
    end

    // Alignment FSM next-state: hunt, verify, hold lock; resync overrides everything
    always_comb begin
        state_nxt   = state;
        offset_nxt  = offset;
        gap_cnt_nxt = gap_cnt;
        hit_cnt_nxt = hit_cnt;
        if (bus.resync) begin
            state_nxt   = SEARCH;
            gap_cnt_nxt = '0;
            hit_cnt_nxt = '0;
        end else begin
            case (state)
                SEARCH: begin
                    if (match) begin
                        gap_cnt_nxt = '0;
                        hit_cnt_nxt = 8'd1;
                        state_nxt   = (LOCK_V == 8'd1) ? LOCKED : VERIFY;
                    end else if (gap_cnt == MAX_GAP_V) begin
                        offset_nxt  = offset_inc;
                        gap_cnt_nxt = '0;
                    end else begin
                        gap_cnt_nxt = gap_cnt + 10'd1;
                    end
                end
                VERIFY: begin
                    if (match) begin
                        hit_cnt_nxt = hit_cnt + 8'd1;
                        gap_cnt_nxt = '0;
                        if (hit_cnt + 8'd1 == LOCK_V) begin
                            state_nxt = LOCKED;
                        end
                    end else if (gap_cnt == MAX_GAP_V) begin
                        state_nxt   = SEARCH;
                        offset_nxt  = offset_inc;
                        gap_cnt_nxt = '0;
                    end else begin
                        gap_cnt_nxt = gap_cnt + 10'd1;
                    end
                end
                LOCKED: begin
                    if (match) begin
                        gap_cnt_nxt = '0;
                    end else if (gap_cnt == MAX_GAP_V) begin
                        state_nxt   = SEARCH;
                        gap_cnt_nxt = '0;
                    end else begin
                        gap_cnt_nxt = gap_cnt + 10'd1;
                    end
                end
                default: begin
                    state_nxt   = SEARCH;
                    gap_cnt_nxt = '0;
                    hit_cnt_nxt = '0;
                end
            endcase
        end
    end

    // Alignment FSM registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= SEARCH;
            offset  <= '0;
            gap_cnt <= '0;
            hit_cnt <= '0;
        end else begin
            state   <= state_nxt;
            offset  <= offset_nxt;
            gap_cnt <= gap_cnt_nxt;
            hit_cnt <= hit_cnt_nxt;
        end
    end

    // Output record: keyed on the next state so the first locked record and the rise of locked coincide
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_record <= IDLE_WORD;
        end else begin
            data_record <= (state_nxt == LOCKED) ? cand : IDLE_WORD;
        end
    end

    assign bus.dataRecord  = data_record;
    assign bus.recordValid = (state == LOCKED);
    assign bus.locked      = (state == LOCKED);
    assign bus.bitOffset   = offset;

`ifdef ALIGNER_STATS_EN
    logic        lock_evt, loss_evt;
    logic [15:0] sync_loss_cnt, lock_cnt;

    // A resync out of LOCKED is not a sync loss
    assign lock_evt = (state != LOCKED) && (state_nxt == LOCKED);
    assign loss_evt = (state == LOCKED) && (state_nxt == SEARCH) && !bus.resync;

    // Saturating lock / loss-of-lock event counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_loss_cnt <= '0;
            lock_cnt      <= '0;
        end else begin
            if (loss_evt && (sync_loss_cnt != 16'hFFFF)) begin
                sync_loss_cnt <= sync_loss_cnt + 16'd1;
            end
            if (lock_evt && (lock_cnt != 16'hFFFF)) begin
                lock_cnt <= lock_cnt + 16'd1;
            end
        end
    end

    assign bus.syncLossCount = sync_loss_cnt;
    assign bus.lockCount     = lock_cnt;
`else
    assign bus.syncLossCount = 16'h0000;
    assign bus.lockCount     = 16'h0000;
`endif

endmodule

// File: tb/tb_data_record_aligner.sv
// tb/tb_data_record_aligner.sv - Scoreboard bench for data_record_aligner
module tb_data_record_aligner;
    localparam logic [39:0] IDLE_WORD = {16'h3C5C, 2'b10, 22'h2AAAAA};
    localparam logic [39:0] HDR_WORD  = {16'h3C5C, 2'b00, 22'h012345};
    localparam logic [39:0] TRL_WORD  = 40'h5A0F0F1234;
`ifdef ALIGNER_STATS_EN
    localparam bit STATS_EN = 1'b1;
`else
    localparam bit STATS_EN = 1'b0;
`endif

    typedef struct {
        int          due;
        logic [39:0] rec;
        logic        valid;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   cyc0  = 0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   k_off   = 0;
    logic [39:0] last_rec = IDLE_WORD;
    exp_t sb_q[$];

    data_record_aligner_if bus_if ();

    data_record_aligner #(
        .LOCK_COUNT(8),
        .MAX_GAP   (15)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [39:0] got, input logic [39:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_stats(input string tag, input int loss, input int lck);
        check_val({tag, "_syncloss"}, 40'(bus_if.syncLossCount), STATS_EN ? 40'(loss) : 40'd0);
        check_val({tag, "_lockcnt"},  40'(bus_if.lockCount),     STATS_EN ? 40'(lck)  : 40'd0);
    endtask

    function automatic logic [39:0] rnd_data();
        logic [63:0] r;
        r = {$urandom, $urandom};
        // every fourth bit forced high: no bit alignment of such a stream can hold 16'h3C5C
        return r[39:0] | 40'h8888888888;
    endfunction

    // Drive the word that places record boundaries k_off bits into each deserializer word
    task automatic put_rec(input logic [39:0] rec, input bit push, input logic [39:0] exp_rec, input logic exp_valid);
        logic [79:0] pair;
        pair = {last_rec, rec};
        bus_if.rawWord = 40'(pair >> k_off);
        last_rec = rec;
        if (push) sb_q.push_back('{cyc + 3, exp_rec, exp_valid});
    endtask

    task automatic send_rec(input logic [39:0] rec, input bit push, input logic [39:0] exp_rec, input logic exp_valid);
        @(negedge clk);
        put_rec(rec, push, exp_rec, exp_valid);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus_if.resync = 1'b0;
        bus_if.rawWord = '0;
        last_rec = IDLE_WORD;
        sb_q.delete();
        repeat (3) @(negedge clk);
        check_val("rst_record", bus_if.dataRecord, IDLE_WORD);
        check_val("rst_valid",  40'(bus_if.recordValid), 40'd0);
        check_val("rst_locked", 40'(bus_if.locked), 40'd0);
        check_val("rst_offset", 40'(bus_if.bitOffset), 40'd0);
        check_stats("rst", 0, 0);
        reset = 1'b0;
        cyc0 = cyc;
    endtask

    // Scoreboard: compare each expected record on the cycle it is due
    always @(negedge clk) begin : monitor
        exp_t e;
        if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
            e = sb_q.pop_front();
            check_val("sb_record", bus_if.dataRecord, e.rec);
            check_val("sb_valid", 40'(bus_if.recordValid), 40'(e.valid));
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int t_off, t_lock, rel;
        logic saw_lock;
        logic [39:0] d;

        bus_if.rawWord = '0;
        bus_if.resync  = 1'b0;

        // Hunt and lock on an idle stream 13 bits off
        k_off = 13;
        do_reset();
        t_off = -1;
        t_lock = -1;
        for (int i = 0; i < 400 && t_lock < 0; i++) begin
            send_rec(IDLE_WORD, 1'b0, IDLE_WORD, 1'b0);
            rel = cyc - cyc0;
            if (t_off < 0 && bus_if.bitOffset == 6'd13) t_off = rel;
            if (t_lock < 0 && bus_if.locked) t_lock = rel;
        end
        check_val("hunt_time", 40'(t_off), 40'd208);
        check_val("lock_after_8", 40'(t_lock - t_off), 40'd8);
        check_val("lock_offset", 40'(bus_if.bitOffset), 40'd13);
        check_stats("lock13", 0, 1);
        for (int n = 0; n < 3; n++) send_rec(IDLE_WORD, 1'b1, IDLE_WORD, 1'b1);

        // 16 data records: loss on the 16th, then relock after 8 syncs
        for (int n = 0; n < 16; n++) begin
            d = rnd_data();
            send_rec(d, 1'b1, (n < 15) ? d : IDLE_WORD, n < 15);
        end
        for (int n = 0; n < 8; n++) send_rec(IDLE_WORD, 1'b1, IDLE_WORD, n == 7);
        for (int n = 0; n < 3; n++) send_rec(IDLE_WORD, 1'b1, IDLE_WORD, 1'b1);
        repeat (4) @(negedge clk);
        check_val("loss_offset", 40'(bus_if.bitOffset), 40'd13);
        check_val("relock", 40'(bus_if.locked), 40'd1);
        check_stats("loss13", 1, 2);

        // False match at offset 5 then verify timeout
        k_off = 5;
        do_reset();
        saw_lock = 1'b0;
        for (int i = 0; i < 110; i++) begin
            @(negedge clk);
            rel = cyc - cyc0;
            if (bus_if.locked) saw_lock = 1'b1;
            if (rel == 96)  check_val("verify_no_slip", 40'(bus_if.bitOffset), 40'd5);
            if (rel == 100) check_val("verify_hold", 40'(bus_if.bitOffset), 40'd5);
            if (rel == 101) check_val("verify_timeout", 40'(bus_if.bitOffset), 40'd6);
            put_rec((rel == 82) ? IDLE_WORD : rnd_data(), 1'b0, IDLE_WORD, 1'b0);
        end
        check_val("false_never_locked", 40'(saw_lock), 40'd0);

        // Lock at offset 39
        k_off = 39;
        do_reset();
        t_lock = -1;
        for (int i = 0; i < 700 && t_lock < 0; i++) begin
            send_rec(IDLE_WORD, 1'b0, IDLE_WORD, 1'b0);
            if (bus_if.locked) t_lock = cyc - cyc0;
        end
        check_val("lock39_time", 40'(t_lock), 40'd632);
        check_val("lock39_offset", 40'(bus_if.bitOffset), 40'd39);

        // Plain resync while locked: drop to idle, relock after 8 syncs
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            bus_if.resync = (n == 2);
            put_rec(IDLE_WORD, 1'b1, IDLE_WORD, n >= 8);
        end
        repeat (4) @(negedge clk);
        check_val("resync_offset", 40'(bus_if.bitOffset), 40'd39);
        check_stats("resync", 0, 2);

        // Resync coincident with gap timeout, then wrap 39 -> 0
        for (int n = 0; n < 36; n++) begin
            @(negedge clk);
            if (n == 33) check_val("prewrap_offset", 40'(bus_if.bitOffset), 40'd39);
            if (n == 34) check_val("wrap_offset", 40'(bus_if.bitOffset), 40'd0);
            bus_if.resync = (n == 17);
            d = rnd_data();
            put_rec(d, n < 16, (n < 15) ? d : IDLE_WORD, n < 15);
        end
        check_val("resync_unlocked", 40'(bus_if.locked), 40'd0);
        check_stats("resync_timeout", 0, 2);

        // Relock at offset 0 and pass a header / data / trailer sequence through
        k_off = 0;
        t_lock = -1;
        for (int i = 0; i < 40 && t_lock < 0; i++) begin
            send_rec(IDLE_WORD, 1'b0, IDLE_WORD, 1'b0);
            if (bus_if.locked) t_lock = 1;
        end
        check_val("lock0", 40'(bus_if.locked), 40'd1);
        check_val("lock0_offset", 40'(bus_if.bitOffset), 40'd0);
        check_stats("lock0", 0, 3);
        send_rec(IDLE_WORD, 1'b1, IDLE_WORD, 1'b1);
        send_rec(HDR_WORD, 1'b1, HDR_WORD, 1'b1);
        for (int n = 0; n < 3; n++) begin
            d = rnd_data();
            send_rec(d, 1'b1, d, 1'b1);
        end
        send_rec(TRL_WORD, 1'b1, TRL_WORD, 1'b1);
        for (int n = 0; n < 2; n++) send_rec(IDLE_WORD, 1'b1, IDLE_WORD, 1'b1);
        repeat (5) @(negedge clk);
        check_val("sb_drained", 40'(sb_q.size()), 40'd0);

        // Asynchronous reset while locked
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check_val("async_rst_record", bus_if.dataRecord, IDLE_WORD);
        check_val("async_rst_valid", 40'(bus_if.recordValid), 40'd0);
        check_val("async_rst_locked", 40'(bus_if.locked), 40'd0);
        check_val("async_rst_offset", 40'(bus_if.bitOffset), 40'd0);
        check_val("async_rst_syncloss", 40'(bus_if.syncLossCount), 40'd0);
        check_val("async_rst_lockcnt", 40'(bus_if.lockCount), 40'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
